// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-port main-memory burst arbiter.
// Port 0 is the D-cache, port 1 the I-cache.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_DONE  = 2'd2
    } arb_state_t;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    localparam int ARB_LINE_WORDS = 16;
    localparam int ARB_CW         = 4;

    // Turn a port index into its bit in a 2-bit per-port vector.
    function automatic logic [1:0] portOneHot(input logic port);
        return {port, ~port};
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin picker used when the arbiter is idle.
// A lone requester always wins; on a tie the port that was not served last wins.
module mem_bus_arbiter_rr_pick2
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_winner,
    output logic       o_valid
);

    // Resolve the winner from the request pair and the last-served port.
    always_comb begin
        o_valid  = |i_req;
        o_winner = PORT_D;
        if (i_req == 2'b11) begin
            o_winner = ~i_last;
        end else if (i_req[PORT_I]) begin
            o_winner = PORT_I;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single main-memory port between the D-cache and I-cache fill /
// write-back engines. Each grant is one full line burst; the arbiter walks
// the beat counter, forms the word address and pulses done to the owner.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LINE_WORDS = ARB_LINE_WORDS,
    parameter int CW         = ARB_CW
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [1:0]      i_req,
    input  logic [1:0]      i_wr,
    input  logic [2*AW-1:0] i_line_addr,
    input  logic [2*DW-1:0] i_wdata,
    output logic [1:0]      o_gnt,
    output logic [CW-1:0]   o_cnt,
    output logic [1:0]      o_done,
    output logic [DW-1:0]   o_rdata,
    output logic            o_mem_rd,
    output logic            o_mem_wr,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_wdata,
    input  logic [DW-1:0]   i_mem_rdata,
    input  logic            i_mem_ack
);

    localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);

    arb_state_t    r_state;
    logic          r_owner;
    logic          r_last;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_gnt;
    logic [1:0]    r_done;
    logic          r_memRd;
    logic          r_memWr;

    logic          w_winner;
    logic          w_valid;
    logic          w_unusedAddrBits;

    mem_bus_arbiter_rr_pick2 u_pick (
        .i_req    (i_req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    // Arbitration FSM: grant from idle, count beats on each ack, then pulse done.
    // The strobe registers double as the direction latched at grant time, so a
    // requester changing wr mid-burst has no effect until its next grant.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ARB_IDLE;
            r_owner <= PORT_D;
            r_last  <= PORT_I;
            r_cnt   <= '0;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_memRd <= 1'b0;
            r_memWr <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_valid) begin
                        r_state <= ARB_BURST;
                        r_owner <= w_winner;
                        r_cnt   <= '0;
                        r_gnt   <= portOneHot(w_winner);
                        r_memRd <= ~i_wr[w_winner];
                        r_memWr <= i_wr[w_winner];
                    end
                end
                ARB_BURST: begin
                    if (i_mem_ack) begin
                        if (r_cnt == LAST_BEAT) begin
                            r_state <= ARB_DONE;
                            r_cnt   <= '0;
                            r_memRd <= 1'b0;
                            r_memWr <= 1'b0;
                            r_done  <= portOneHot(r_owner);
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ARB_DONE: begin
                    r_state <= ARB_IDLE;
                    r_done  <= 2'b00;
                    r_gnt   <= 2'b00;
                    r_last  <= r_owner;
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_cnt   <= '0;
                    r_gnt   <= 2'b00;
                    r_done  <= 2'b00;
                    r_memRd <= 1'b0;
                    r_memWr <= 1'b0;
                end
            endcase
        end
    end

    // Owner's line address is used live; the low bits are replaced by the beat index.
    always_comb begin
        if (r_owner == PORT_I) begin
            o_mem_addr  = {i_line_addr[2*AW-1:AW+CW], r_cnt};
            o_mem_wdata = i_wdata[2*DW-1:DW];
        end else begin
            o_mem_addr  = {i_line_addr[AW-1:CW], r_cnt};
            o_mem_wdata = i_wdata[DW-1:0];
        end
    end

    // Line-offset bits of the request addresses carry no information.
    assign w_unusedAddrBits = &{1'b0, i_line_addr[AW+CW-1:AW], i_line_addr[CW-1:0]};

    assign o_gnt    = r_gnt;
    assign o_cnt    = r_cnt;
    assign o_done   = r_done;
    assign o_mem_rd = r_memRd;
    assign o_mem_wr = r_memWr;
    assign o_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: each request round pushes the bursts
// the arbitration rules predict; a monitor retires them beat by beat.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int CW = 4;

    typedef struct {
        logic          port;
        logic          wr;
        logic [AW-1:0] addr;
        logic          isLast;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [1:0]      i_req = 2'b00;
    logic [1:0]      i_wr = 2'b00;
    logic [2*AW-1:0] i_line_addr = '0;
    logic [2*DW-1:0] i_wdata = '0;
    logic [DW-1:0]   i_mem_rdata = '0;
    logic            i_mem_ack = 1'b0;
    logic [1:0]      o_gnt;
    logic [CW-1:0]   o_cnt;
    logic [1:0]      o_done;
    logic [DW-1:0]   o_rdata;
    logic            o_mem_rd;
    logic            o_mem_wr;
    logic [AW-1:0]   o_mem_addr;
    logic [DW-1:0]   o_mem_wdata;

    beat_t         beatQ[$];
    int            compared = 0;
    int            mismatched = 0;
    int            cycle = 0;
    int            ackMode = 0;
    logic          ackPhase = 1'b0;
    logic          modelLast = 1'b1;
    logic          expDoneValid = 1'b0;
    int            expDoneCycle = 0;
    logic          expDonePort = 1'b0;
    logic [DW-1:0] tbWdata [2];
    logic [1:0]    roundWr = 2'b00;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .LINE_WORDS(LW), .CW(CW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (i_req),
        .i_wr        (i_wr),
        .i_line_addr (i_line_addr),
        .i_wdata     (i_wdata),
        .o_gnt       (o_gnt),
        .o_cnt       (o_cnt),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_mem_rd    (o_mem_rd),
        .o_mem_wr    (o_mem_wr),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ack   (i_mem_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [1:0] oneHot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [DW-1:0] readPattern(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic pushBurst(input logic port, input logic wr, input logic [AW-1:0] base);
        beat_t b;
        for (int i = 0; i < LW; i++) begin
            b.port   = port;
            b.wr     = wr;
            b.addr   = {base[AW-1:CW], CW'(i)};
            b.isLast = (i == LW - 1);
            beatQ.push_back(b);
        end
    endtask

    // Memory model: ack pattern, read data derived from the address, fresh write data.
    always @(posedge clk) begin
        #2;
        case (ackMode)
            0: i_mem_ack = 1'b1;
            1: begin
                ackPhase  = ~ackPhase;
                i_mem_ack = ackPhase;
            end
            default: i_mem_ack = ($urandom_range(0, 2) != 0);
        endcase
        tbWdata[0]  = $urandom;
        tbWdata[1]  = $urandom;
        i_wdata     = {tbWdata[1], tbWdata[0]};
        i_mem_rdata = readPattern(o_mem_addr);
    end

    // Monitor: invariants every cycle, retire a beat on every acked strobe, check done timing.
    always @(negedge clk) begin
        beat_t      exp;
        logic [1:0] expDone;
        if (!rst) begin
            checkOutput("gntOneHot0", 64'($onehot0(o_gnt)), 64'd1);
            checkOutput("rdWrExclusive", 64'(o_mem_rd && o_mem_wr), 64'd0);
            if (beatQ.size() > 0 && o_gnt == oneHot(beatQ[0].port) && o_done == 2'b00) begin
                checkOutput("strobeDir", {o_mem_wr, o_mem_rd}, {beatQ[0].wr, ~beatQ[0].wr});
                checkOutput("beatCnt", o_cnt, beatQ[0].addr[CW-1:0]);
                checkOutput("memAddr", o_mem_addr, beatQ[0].addr);
            end
            if ((o_mem_rd || o_mem_wr) && i_mem_ack) begin
                if (beatQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpectedBeat: addr 0x%0h with no burst outstanding (t=%0t)", o_mem_addr, $time);
                end else begin
                    exp = beatQ.pop_front();
                    checkOutput("beatGnt", o_gnt, oneHot(exp.port));
                    if (exp.wr) checkOutput("memWdata", o_mem_wdata, tbWdata[exp.port]);
                    else        checkOutput("rdata", o_rdata, readPattern(exp.addr));
                    if (exp.isLast) begin
                        expDoneValid = 1'b1;
                        expDoneCycle = cycle + 1;
                        expDonePort  = exp.port;
                    end
                end
            end
            expDone = (expDoneValid && cycle == expDoneCycle) ? oneHot(expDonePort) : 2'b00;
            if (o_done != 2'b00 || expDone != 2'b00) begin
                checkOutput("donePulse", o_done, expDone);
                if (expDone != 2'b00) begin
                    checkOutput("doneStrobesLow", {o_mem_wr, o_mem_rd}, 2'b00);
                    checkOutput("doneGntHeld", o_gnt, expDone);
                    expDoneValid = 1'b0;
                end
            end
        end
    end

    // Assert reset right now, check the cleared outputs, and drop all expectations.
    task automatic resetDut();
        rst   = 1'b1;
        i_req = 2'b00;
        #1;
        checkOutput("rstGnt", o_gnt, 2'b00);
        checkOutput("rstCnt", o_cnt, 4'd0);
        checkOutput("rstDone", o_done, 2'b00);
        checkOutput("rstStrobes", {o_mem_wr, o_mem_rd}, 2'b00);
        beatQ.delete();
        expDoneValid = 1'b0;
        modelLast    = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One request round from idle; the reference order follows the round-robin rules.
    task automatic applyStimulus(input logic [1:0] mask, input logic [1:0] wrBits,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input int lateDelay, input bit repeatFirst);
        logic       first;
        logic       second;
        int         doneNeeded [2];
        logic [1:0] seenDone;
        bit         finished;
        if (mask == 2'b11) begin
            first  = ~modelLast;
            second = modelLast;
        end else begin
            first  = mask[1];
            second = ~mask[1];
        end
        doneNeeded[0] = 0;
        doneNeeded[1] = 0;
        pushBurst(first, wrBits[first], first ? a1 : a0);
        doneNeeded[first]++;
        modelLast = first;
        if (mask == 2'b11 || lateDelay > 0) begin
            pushBurst(second, wrBits[second], second ? a1 : a0);
            doneNeeded[second]++;
            modelLast = second;
            if (repeatFirst) begin
                pushBurst(first, wrBits[first], first ? a1 : a0);
                doneNeeded[first]++;
                modelLast = first;
            end
        end
        @(posedge clk);
        #1;
        i_wr        = wrBits;
        roundWr     = wrBits;
        i_line_addr = {a1, a0};
        i_req       = (lateDelay > 0) ? oneHot(first) : mask;
        @(negedge clk);
        checkOutput("gntBeforeSample", o_gnt, 2'b00);
        @(negedge clk);
        checkOutput("gntLatency", o_gnt, oneHot(first));
        finished = 1'b0;
        for (int c = 0; c < 800 && !finished; c++) begin
            @(negedge clk);
            seenDone = o_done;
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (seenDone[p]) begin
                    doneNeeded[p]--;
                    i_wr[p] = roundWr[p];
                    if (doneNeeded[p] <= 0) i_req[p] = 1'b0;
                end else if (o_gnt[p] && $urandom_range(0, 3) == 0) begin
                    i_wr[p] = ~i_wr[p];
                end
            end
            if (lateDelay > 0 && c == lateDelay) i_req[second] = 1'b1;
            if (i_req == 2'b00 && o_gnt == 2'b00) finished = 1'b1;
        end
        if (!finished) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL roundTimeout: gnt=0x%0h req=0x%0h, %0d beats still queued", o_gnt, i_req, beatQ.size());
            @(negedge clk);
            resetDut();
        end
    endtask

    initial begin
        logic [1:0] m;
        int         late;
        bit         rep;
        bit         found;
        #3;
        resetDut();

        $display("[TB] single D-cache load, ack every cycle");
        ackMode = 0;
        applyStimulus(2'b01, 2'b00, 32'h0000_0100, 32'h0000_0000, 0, 1'b0);

        $display("[TB] both ports from reset, owner re-requests");
        @(negedge clk);
        resetDut();
        applyStimulus(2'b11, 2'b10, 32'h0000_4A30, 32'h8000_1200, 0, 1'b1);

        $display("[TB] I-cache store with ack every other cycle");
        ackMode = 1;
        applyStimulus(2'b10, 2'b10, 32'h0000_0000, 32'hABCD_0040, 0, 1'b0);

        $display("[TB] I-cache request rises mid D-cache burst");
        ackMode = 2;
        applyStimulus(2'b01, 2'b01, 32'h1234_5670, 32'h0BAD_F000, 5, 1'b0);

        $display("[TB] reset mid-burst at beat 7");
        ackMode = 0;
        @(posedge clk);
        #1;
        i_wr        = 2'b00;
        i_line_addr = {32'h0, 32'h0000_2000};
        i_req       = 2'b01;
        pushBurst(1'b0, 1'b0, 32'h0000_2000);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (o_gnt == 2'b01 && o_cnt == 4'd7) found = 1'b1;
        end
        if (!found) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL reachBeat7: cnt=%0d gnt=0x%0h", o_cnt, o_gnt);
        end
        resetDut();
        applyStimulus(2'b01, 2'b00, 32'h0000_2000, 32'h0000_0000, 0, 1'b0);

        $display("[TB] random traffic");
        ackMode = 2;
        for (int r = 0; r < 24; r++) begin
            m    = 2'($urandom_range(1, 3));
            late = 0;
            rep  = 1'b0;
            if (m != 2'b11 && $urandom_range(0, 1) == 1) late = $urandom_range(2, 10);
            if (m == 2'b11) rep = ($urandom_range(0, 1) == 1);
            applyStimulus(m, 2'($urandom), $urandom, $urandom, late, rep);
        end

        repeat (4) @(posedge clk);
        if (beatQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL leftoverBeats: %0d still queued, required 0", beatQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, %0d mismatched so far", mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
